// File: rtl/priority_mux_pkg.sv
// Shared helpers for the priority_mux slice: index-width calculation used by
// the interface, the encoder and the top so all three agree on grant_idx width.
package priority_mux_pkg;

  // A single slot still needs a 1-bit index port; $clog2(1) would be 0.
  function automatic int idx_width(input int cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

endpackage

// File: rtl/priority_mux_if.sv
// Bundle of data/select inputs and selected/registered outputs of priority_mux.
// master drives din/sel; slave (the mux) drives every result.
interface priority_mux_if
  import priority_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT   = 1
) ();

  localparam int IDXW = idx_width(CNT);

  logic [WIDTH*CNT-1:0] din;
  logic [CNT-1:0]       sel;
  logic [WIDTH-1:0]     dout;
  logic                 hit;
  logic [CNT-1:0]       grant;
  logic [IDXW-1:0]      grant_idx;
  logic [WIDTH-1:0]     dout_q;
  logic                 hit_q;

  modport master (
    output din, sel,
    input  dout, hit, grant, grant_idx, dout_q, hit_q
  );

  modport slave (
    input  din, sel,
    output dout, hit, grant, grant_idx, dout_q, hit_q
  );

endinterface

// File: rtl/priority_mux_prio_enc.sv
// Lowest-index-wins priority encoder: isolates the lowest set select bit and
// reports it both one-hot and as a binary index.
module prio_enc
  import priority_mux_pkg::*;
#(
  parameter int CNT  = 1,
  parameter int IDXW = idx_width(CNT)
) (
  input  logic [CNT-1:0]  sel,
  output logic [CNT-1:0]  grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            hit
);

  // Two's-complement trick: sel - 1 flips the lowest set bit and everything
  // below it, so masking leaves only that bit. sel == 0 yields grant == 0.
  assign grant = sel & ~(sel - CNT'(1));
  assign hit   = |sel;

  // grant is one-hot, so OR-ing the indices of its set bits gives the winner
  // and naturally produces 0 when nothing is selected.
  always_comb begin
    // NOTE: default first so every path assigns grant_idx; otherwise a latch is inferred.
    grant_idx = '0;
    for (int i = 0; i < CNT; i++) begin
      if (grant[i]) grant_idx = grant_idx | IDXW'(i);
    end
  end

endmodule

// File: rtl/priority_mux.sv
// Priority-selected data mux for the sw-access write path: combinational
// dout/hit/grant/grant_idx plus one-cycle registered dout_q/hit_q.
module priority_mux
  import priority_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  priority_mux_if.slave  bus
);

  localparam int IDXW = idx_width(CNT);

  logic [CNT-1:0]   grant;
  logic [IDXW-1:0]  grant_idx;
  logic             hit;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_q;
  logic             hit_q;

  prio_enc #(
    .CNT  (CNT),
    .IDXW (IDXW)
  ) u_prio_enc (
    .sel       (bus.sel),
    .grant     (grant),
    .grant_idx (grant_idx),
    .hit       (hit)
  );

  // AND-OR mux over the one-hot grant: unselected slots are masked to zero,
  // so X on an idle slot cannot reach dout.
  always_comb begin
    dout = '0;
    for (int i = 0; i < CNT; i++) begin
      dout = dout | (bus.din[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for state, so every register samples pre-edge values.
    if (!rst_n) begin
      dout_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      dout_q <= dout;
      hit_q  <= hit;
    end
  end

  assign bus.dout      = dout;
  assign bus.hit       = hit;
  assign bus.grant     = grant;
  assign bus.grant_idx = grant_idx;
  assign bus.dout_q    = dout_q;
  assign bus.hit_q     = hit_q;

endmodule

// File: tb/tb_priority_mux.sv
// Scoreboard bench for priority_mux: stimulus pushes expected results,
// negedge monitors pop and compare both a CNT=3 and a CNT=1 instance.
module tb_priority_mux;
  import priority_mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  priority_mux_if #(.WIDTH(4), .CNT(3)) bus3 ();
  priority_mux_if #(.WIDTH(8), .CNT(1)) bus1 ();

  priority_mux #(.WIDTH(4), .CNT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  priority_mux #(.WIDTH(8), .CNT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  typedef struct {
    string      tag;
    logic [3:0] dout;
    logic       hit;
    logic [2:0] grant;
    logic [1:0] idx;
    logic [3:0] dout_q;
    logic       hit_q;
  } exp3_t;

  typedef struct {
    string      tag;
    logic [7:0] dout;
    logic       hit;
    logic       grant;
    logic       idx;
    logic [7:0] dout_q;
    logic       hit_q;
  } exp1_t;

  exp3_t sb3[$];
  exp1_t sb1[$];

  // Model of what the previous cycle presented, captured at the next edge.
  logic [3:0] m3_dout = '0;
  logic       m3_hit  = 1'b0;
  logic       m3_rst  = 1'b0;
  logic [7:0] m1_dout = '0;
  logic       m1_hit  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: scan from the top so the lowest set index is written last.
  function automatic exp3_t ref3(input logic [2:0] s, input logic [11:0] d);
    exp3_t r;
    r.tag = "rand"; r.dout = '0; r.hit = 1'b0; r.grant = '0; r.idx = '0;
    r.dout_q = '0; r.hit_q = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (s[i]) begin
        r.dout  = d[i*4 +: 4];
        r.grant = 3'b001 << i;
        r.idx   = 2'(i);
        r.hit   = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic drive3(input string tag, input logic [2:0] s, input logic [11:0] d, input logic r,
                        input logic [3:0] e_dout, input logic e_hit, input logic [2:0] e_grant,
                        input logic [1:0] e_idx);
    exp3_t e;
    @(posedge clk);
    e.tag    = tag;
    e.dout   = e_dout;
    e.hit    = e_hit;
    e.grant  = e_grant;
    e.idx    = e_idx;
    e.dout_q = m3_rst ? m3_dout : 4'h0;
    e.hit_q  = m3_rst ? m3_hit  : 1'b0;
    #1;
    bus3.sel = s;
    bus3.din = d;
    rst_n    = r;
    sb3.push_back(e);
    m3_dout = e_dout;
    m3_hit  = e_hit;
    m3_rst  = r;
  endtask

  task automatic drive1(input string tag, input logic s, input logic [7:0] d,
                        input logic [7:0] e_dout, input logic e_hit);
    exp1_t e;
    @(posedge clk);
    e.tag    = tag;
    e.dout   = e_dout;
    e.hit    = e_hit;
    e.grant  = e_hit;
    e.idx    = 1'b0;
    e.dout_q = m1_dout;
    e.hit_q  = m1_hit;
    #1;
    bus1.sel = s;
    bus1.din = d;
    sb1.push_back(e);
    m1_dout = e_dout;
    m1_hit  = e_hit;
  endtask

  always @(negedge clk) begin
    if (sb3.size() > 0) begin
      exp3_t e;
      e = sb3.pop_front();
      check({e.tag, ".dout"},      bus3.dout,      e.dout);
      check({e.tag, ".hit"},       bus3.hit,       e.hit);
      check({e.tag, ".grant"},     bus3.grant,     e.grant);
      check({e.tag, ".grant_idx"}, bus3.grant_idx, e.idx);
      check({e.tag, ".dout_q"},    bus3.dout_q,    e.dout_q);
      check({e.tag, ".hit_q"},     bus3.hit_q,     e.hit_q);
    end
  end

  always @(negedge clk) begin
    if (sb1.size() > 0) begin
      exp1_t e;
      e = sb1.pop_front();
      check({e.tag, ".dout"},      bus1.dout,      e.dout);
      check({e.tag, ".hit"},       bus1.hit,       e.hit);
      check({e.tag, ".grant"},     bus1.grant,     e.grant);
      check({e.tag, ".grant_idx"}, bus1.grant_idx, e.idx);
      check({e.tag, ".dout_q"},    bus1.dout_q,    e.dout_q);
      check({e.tag, ".hit_q"},     bus1.hit_q,     e.hit_q);
    end
  end

  initial begin
    exp3_t  r;
    logic [2:0]  s;
    logic [11:0] d;
    bus3.sel = '0; bus3.din = '0;
    bus1.sel = '0; bus1.din = '0;

    // Reset then the idle pattern.
    drive3("rst0",  3'b000, 12'hCBA, 1'b0, 4'h0, 1'b0, 3'b000, 2'd0);
    drive3("rst1",  3'b000, 12'hCBA, 1'b0, 4'h0, 1'b0, 3'b000, 2'd0);
    drive3("none",  3'b000, 12'hCBA, 1'b1, 4'h0, 1'b0, 3'b000, 2'd0);
    drive3("none2", 3'b000, 12'hCBA, 1'b1, 4'h0, 1'b0, 3'b000, 2'd0);
    // One strobe per slot.
    drive3("s0",    3'b001, 12'hCBA, 1'b1, 4'hA, 1'b1, 3'b001, 2'd0);
    drive3("s1",    3'b010, 12'hCBA, 1'b1, 4'hB, 1'b1, 3'b010, 2'd1);
    drive3("s2",    3'b100, 12'hCBA, 1'b1, 4'hC, 1'b1, 3'b100, 2'd2);
    // Conflicts: lowest index wins.
    drive3("c110",  3'b110, 12'hCBA, 1'b1, 4'hB, 1'b1, 3'b010, 2'd1);
    drive3("c111",  3'b111, 12'hCBA, 1'b1, 4'hA, 1'b1, 3'b001, 2'd0);
    drive3("c101",  3'b101, 12'hCBA, 1'b1, 4'hA, 1'b1, 3'b001, 2'd0);
    // Registered path: C captured, then drop to idle.
    drive3("reg100",  3'b100, 12'hCBA, 1'b1, 4'hC, 1'b1, 3'b100, 2'd2);
    drive3("reg000",  3'b000, 12'hCBA, 1'b1, 4'h0, 1'b0, 3'b000, 2'd0);
    drive3("regidle", 3'b000, 12'hCBA, 1'b1, 4'h0, 1'b0, 3'b000, 2'd0);
    // Reset held for two edges with slot 1 selected, then released.
    drive3("rsta",  3'b010, 12'hCBA, 1'b0, 4'hB, 1'b1, 3'b010, 2'd1);
    drive3("rstb",  3'b010, 12'hCBA, 1'b0, 4'hB, 1'b1, 3'b010, 2'd1);
    drive3("rel",   3'b010, 12'hCBA, 1'b1, 4'hB, 1'b1, 3'b010, 2'd1);
    drive3("rel2",  3'b010, 12'hCBA, 1'b1, 4'hB, 1'b1, 3'b010, 2'd1);

    // Single-slot instance.
    drive1("w1_s1",  1'b1, 8'h5A, 8'h5A, 1'b1);
    drive1("w1_s0",  1'b0, 8'h5A, 8'h00, 1'b0);
    drive1("w1_s0b", 1'b0, 8'h5A, 8'h00, 1'b0);

    // Random traffic against the reference model.
    for (int n = 0; n < 1000; n++) begin
      s = 3'($urandom_range(0, 7));
      d = 12'($urandom);
      r = ref3(s, d);
      drive3("rand", s, d, 1'b1, r.dout, r.hit, r.grant, r.idx);
    end

    // Bounded drain of the scoreboards.
    for (int n = 0; n < 10; n++) begin
      if (sb3.size() == 0 && sb1.size() == 0) break;
      @(negedge clk);
    end
    #1;
    check("drain", 32'(sb3.size() + sb1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
